uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte FIFO plus launch controller directly upstream of the UART transmitter.
- Accepts bytes from the host or register side with a simple write strobe and buffers them.
- Drives the transmitter's tx_en and data_in one byte at a time, using the transmitter's busy_tx/done_tx status to pace transfers.
- Lets software queue a burst without polling the transmitter per byte.

Parameters:
- DATA_W, 8, byte width; must match the transmitter data_in width.
- DEPTH, 16, FIFO entries; must be a power of 2, range 2..256.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  write strobe; one byte per cycle.
- wr_data  in  DATA_W  byte to queue.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  AW+1  current entry count, 0..DEPTH.
- tx_en  out  1  one-cycle launch pulse to the transmitter's tx_en.
- tx_data  out  DATA_W  byte to the transmitter's data_in; held stable from launch until done.
- tx_busy  in  1  transmitter busy_tx.
- tx_done  in  1  transmitter done_tx, one-cycle pulse at end of frame.
- idle  out  1  FSM in IDLE and FIFO empty.

Behaviour:
- Reset (async, rst=1):
  - rd_ptr=0, wr_ptr=0, level=0, full=0, empty=1.
  - tx_en=0, tx_data=0, idle=1, FSM=IDLE.
  - Memory contents are don't-care.
  - Reset mid-frame discards all queued bytes and any in-flight handshake; no tx_en pulse is emitted during or immediately after reset.
- Write:
  - Accepted on a rising edge iff wr_en=1 and full=0: mem[wr_ptr]<=wr_data, wr_ptr+1 (wraps mod DEPTH).
  - wr_en while full=1: byte dropped, pointers and level unchanged.
- Pop: occurs only on the IDLE->START transition: tx_data<=mem[rd_ptr], rd_ptr+1 (wraps mod DEPTH).
- level:
  - +1 on an accepted write, -1 on a pop, unchanged when both occur in the same cycle.
  - full=(level==DEPTH), empty=(level==0); both are registered, derived from the post-edge level.
- Full boundary: a pop and a write in the same cycle while full is not possible, because writes are refused when full. full drops one cycle after the pop.
- Empty boundary: a write into an empty FIFO is not visible to the FSM until the next cycle (no fall-through).
- FSM, all outputs registered:
  - IDLE: if empty=0 and tx_busy=0 -> START, performing the pop; else stay.
  - START: tx_en=1 for exactly this cycle. Next -> WAIT, or -> IDLE if tx_done=1 in this cycle.
  - WAIT: tx_en=0, tx_data held. On tx_done=1 -> IDLE.
- Latency:
  - Write in cycle 0 into an empty, idle queue: level=1 in cycle 1, tx_en=1 in cycle 2.
  - Back-to-back bytes: tx_done in cycle n gives IDLE in n+1 and the next tx_en in n+2.
- tx_busy=1 seen in IDLE (transmitter occupied by another source) blocks launch.
- tx_data changes only on a pop.
- idle=1 iff FSM=IDLE and empty=1.

Optional Feature:
- Macro: UART_TXQ_OVF_FLAG_EN.
- Defined:
  - Adds output ovf (1 bit) and input ovf_clr (1 bit).
  - ovf is set on any cycle with wr_en=1 and full=1; it is sticky.
  - ovf is cleared when ovf_clr=1, but only if no new overflow occurs in the same cycle (set wins).
  - Reset value 0.
- Not defined: ports ovf and ovf_clr are absent; overflowing writes are silently dropped.

Test Plan:
- Reset then write 0xA5 in cycle 0 (tx_busy=0) -> level=1 in cycle 1; tx_en=1 and tx_data=0xA5 in cycle 2 only; level=0 in cycle 3; after tx_done: idle=1.
- Write 16 bytes 0x00..0x0F with tx_busy held 1 -> full=1 and level=16. A 17th write of 0xFF is dropped. Release tx_busy and return tx_done after each tx_en -> tx_data sequence is exactly 0x00..0x0F; 0xFF never appears.
- Write 3 bytes and return tx_done 10 cycles after each tx_en -> exactly 3 tx_en pulses, each 2 cycles after the preceding tx_done. tx_data is stable throughout each WAIT.
- Fill the FIFO, then write 1 byte in the cycle the pop occurs -> write refused (full was 1); full=0 the following cycle; a fresh write is then accepted and level returns to 16.
- Assert rst for 1 cycle while in WAIT with 5 bytes queued -> level=0, empty=1, tx_en=0. A later tx_done pulse causes no tx_en.
- With UART_TXQ_OVF_FLAG_EN defined: write when full -> ovf=1 the next cycle. ovf_clr=1 alone -> ovf=0. ovf_clr=1 together with an overflowing write -> ovf stays 1.

Source files
------------

// File: rtl/uart_tx_queue_if.sv
// Bundle between the byte queue and its environment (host write side plus transmitter status).
// UART_TXQ_OVF_FLAG_EN adds the sticky overflow flag and its clear input.
interface uart_tx_queue_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 4
);
  // Write side: a byte is taken on any clock with wr_en=1 and full=0; there is no back-pressure
  // beyond full. Launch side: tx_en pulses one cycle with tx_data valid, tx_data holds until tx_done.
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [AW:0]       level;
  logic              tx_en;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              tx_done;
  logic              idle;
  logic [1:0]        dbg_state;
`ifdef UART_TXQ_OVF_FLAG_EN
  logic              ovf;
  logic              ovf_clr;

  modport master (
    output wr_en, wr_data, tx_busy, tx_done, ovf_clr,
    input  full, empty, level, tx_en, tx_data, idle, dbg_state, ovf
  );
  modport slave (
    input  wr_en, wr_data, tx_busy, tx_done, ovf_clr,
    output full, empty, level, tx_en, tx_data, idle, dbg_state, ovf
  );
`else
  modport master (
    output wr_en, wr_data, tx_busy, tx_done,
    input  full, empty, level, tx_en, tx_data, idle, dbg_state
  );
  modport slave (
    input  wr_en, wr_data, tx_busy, tx_done,
    output full, empty, level, tx_en, tx_data, idle, dbg_state
  );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO and launch controller feeding a UART transmitter one byte per frame.
// Optional sticky overflow flag enabled by defining UART_TXQ_OVF_FLAG_EN.
module uart_tx_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_queue_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_full;
  logic              r_empty;
  logic              r_tx_en;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_idle;

  logic              w_wr_accept;
  logic              w_pop;
  logic [AW:0]       w_level_next;
  logic              w_level_next_zero;

  assign w_wr_accept       = bus.wr_en && !r_full;
  assign w_pop             = (r_state == S_IDLE) && !r_empty && !bus.tx_busy;
  assign w_level_next_zero = (w_level_next == '0);

  always_comb begin
    w_level_next = r_level;
    case ({w_wr_accept, w_pop})
      2'b10:   w_level_next = r_level + 1'b1;
      2'b01:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is 2**AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_next;
      r_full  <= (w_level_next == (AW+1)'(DEPTH));
      r_empty <= w_level_next_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_idle    <= 1'b1;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state   <= S_START;
            r_tx_en   <= 1'b1;
            r_tx_data <= r_mem[r_rd_ptr];
            r_idle    <= 1'b0;
          end else begin
            r_idle <= w_level_next_zero;
          end
        end
        S_START: begin
          // A frame may finish in the launch cycle itself; skip WAIT then.
          if (bus.tx_done) begin
            r_state <= S_IDLE;
            r_idle  <= w_level_next_zero;
          end else begin
            r_state <= S_WAIT;
            r_idle  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.tx_done) begin
            r_state <= S_IDLE;
            r_idle  <= w_level_next_zero;
          end else begin
            r_idle <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= w_level_next_zero;
        end
      endcase
    end
  end

`ifdef UART_TXQ_OVF_FLAG_EN
  logic r_ovf;

  // A new overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (bus.wr_en && r_full) begin
      r_ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.level     = r_level;
  assign bus.tx_en     = r_tx_en;
  assign bus.tx_data   = r_tx_data;
  assign bus.idle      = r_idle;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: per-cycle vector table plus hand-written multi-cycle sequences.
// Covers the optional overflow flag when UART_TXQ_OVF_FLAG_EN is defined.
module tb_uart_tx_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [DATA_W-1:0] exp_q[$];

  uart_tx_queue_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  uart_tx_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
`ifdef UART_TXQ_OVF_FLAG_EN
    bus.ovf_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [DATA_W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_tx_en(input int budget, output bit ok, output int cycles);
    ok     = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      if (bus.tx_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_tx_en timeout after %0d cycles", budget);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              tx_busy;
    logic              tx_done;
    logic [AW:0]       level;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;
    logic              idle;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic w, input logic [7:0] wd, input logic b, input logic d,
                              input logic [4:0] l, input logic e, input logic [7:0] td,
                              input logic i);
    vec_t v;
    v.wr_en = w; v.wr_data = wd; v.tx_busy = b; v.tx_done = d;
    v.level = l; v.tx_en = e; v.tx_data = td; v.idle = i;
    return v;
  endfunction

  initial begin
    bit ok;
    int cyc;
    logic [DATA_W-1:0] d;

    checks   = 0;
    failures = 0;
    clear_inputs();
    rst = 1'b1;

    // Expected outputs are those seen after the edge that consumes the inputs.
    vecs[0]  = mk(1, 8'hA5, 0, 0, 1, 0, 8'h00, 0);
    vecs[1]  = mk(0, 8'h00, 0, 0, 0, 1, 8'hA5, 0);
    vecs[2]  = mk(0, 8'h00, 0, 0, 0, 0, 8'hA5, 0);
    vecs[3]  = mk(0, 8'h00, 0, 0, 0, 0, 8'hA5, 0);
    vecs[4]  = mk(0, 8'h00, 0, 1, 0, 0, 8'hA5, 1);
    vecs[5]  = mk(0, 8'h00, 0, 0, 0, 0, 8'hA5, 1);
    vecs[6]  = mk(1, 8'hB7, 0, 0, 1, 0, 8'hA5, 0);
    vecs[7]  = mk(0, 8'h00, 0, 0, 0, 1, 8'hB7, 0);
    vecs[8]  = mk(0, 8'h00, 0, 1, 0, 0, 8'hB7, 1);
    vecs[9]  = mk(0, 8'h00, 0, 0, 0, 0, 8'hB7, 1);
    vecs[10] = mk(1, 8'h3C, 1, 0, 1, 0, 8'hB7, 0);
    vecs[11] = mk(0, 8'h00, 1, 0, 1, 0, 8'hB7, 0);
    vecs[12] = mk(0, 8'h00, 0, 0, 0, 1, 8'h3C, 0);
    vecs[13] = mk(0, 8'h00, 0, 1, 0, 0, 8'h3C, 1);

    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_level", bus.level, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_tx_en", bus.tx_en, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_idle", bus.idle, 1);
`ifdef UART_TXQ_OVF_FLAG_EN
    chk("rst_ovf", bus.ovf, 0);
`endif

    for (int i = 0; i < 14; i++) begin
      bus.wr_en   = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      bus.tx_busy = vecs[i].tx_busy;
      bus.tx_done = vecs[i].tx_done;
      tick();
      chk($sformatf("vec%0d_level", i), bus.level, vecs[i].level);
      chk($sformatf("vec%0d_empty", i), bus.empty, (vecs[i].level == 0));
      chk($sformatf("vec%0d_full", i), bus.full, 0);
      chk($sformatf("vec%0d_tx_en", i), bus.tx_en, vecs[i].tx_en);
      chk($sformatf("vec%0d_tx_data", i), bus.tx_data, vecs[i].tx_data);
      chk($sformatf("vec%0d_idle", i), bus.idle, vecs[i].idle);
    end
    clear_inputs();

    // Fill to full while blocked, drop 17th byte, then drain in order
    do_reset();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    chk("fill_full", bus.full, 1);
    chk("fill_level", bus.level, 16);
    chk("fill_tx_en", bus.tx_en, 0);
    write_byte(8'hFF);
    chk("drop_level", bus.level, 16);
    chk("drop_full", bus.full, 1);
`ifdef UART_TXQ_OVF_FLAG_EN
    chk("ovf_set", bus.ovf, 1);
    bus.ovf_clr = 1'b1;
    tick();
    chk("ovf_clr_alone", bus.ovf, 0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hFF;
    tick();
    bus.wr_en   = 1'b0;
    chk("ovf_set_wins", bus.ovf, 1);
    chk("ovf_drop_level", bus.level, 16);
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr_again", bus.ovf, 0);
`endif
    bus.tx_busy = 1'b0;
    for (int n = 0; n < DEPTH; n++) begin
      wait_tx_en(20, ok, cyc);
      if (!ok) break;
      d = exp_q.pop_front();
      chk($sformatf("drain%0d_tx_data", n), bus.tx_data, d);
      tick();
      tick();
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
    chk("drain_remaining", exp_q.size(), 0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("drain_no_extra_tx_en", bus.tx_en, 0);
    end
    chk("drain_idle", bus.idle, 1);
    chk("drain_empty", bus.empty, 1);

    // Paced frames: tx_done 10 cycles after each launch, next launch 2 cycles after done
    do_reset();
    bus.tx_busy = 1'b1;
    write_byte(8'h11); exp_q.push_back(8'h11);
    write_byte(8'h22); exp_q.push_back(8'h22);
    write_byte(8'h33); exp_q.push_back(8'h33);
    bus.tx_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_tx_en(20, ok, cyc);
      if (!ok) break;
      if (k > 0) chk($sformatf("pace%0d_gap", k), cyc + 1, 2);
      d = exp_q.pop_front();
      chk($sformatf("pace%0d_tx_data", k), bus.tx_data, d);
      for (int j = 0; j < 10; j++) begin
        tick();
        chk($sformatf("pace%0d_wait_tx_en", k), bus.tx_en, 0);
        chk($sformatf("pace%0d_wait_data", k), bus.tx_data, d);
      end
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("pace_no_4th", bus.tx_en, 0);
    end
    chk("pace_idle", bus.idle, 1);

    // Full boundary: write in the pop cycle is refused, then accepted once full drops
    do_reset();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_byte(8'hA0 + 8'(i));
    chk("bnd_full", bus.full, 1);
    bus.tx_busy = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    bus.wr_en   = 1'b0;
    chk("bnd_pop_tx_en", bus.tx_en, 1);
    chk("bnd_pop_tx_data", bus.tx_data, 8'hA0);
    chk("bnd_refused_level", bus.level, 15);
    chk("bnd_full_dropped", bus.full, 0);
    write_byte(8'h77);
    chk("bnd_refill_level", bus.level, 16);
    chk("bnd_refill_full", bus.full, 1);

    // Reset while waiting on a frame with bytes still queued
    do_reset();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) write_byte(8'h50 + 8'(i));
    bus.tx_busy = 1'b0;
    wait_tx_en(20, ok, cyc);
    tick();
    chk("mid_wait_level", bus.level, 5);
    chk("mid_wait_state", bus.dbg_state, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_empty", bus.empty, 1);
    chk("mid_rst_tx_en", bus.tx_en, 0);
    chk("mid_rst_idle", bus.idle, 1);
    tick();
    rst = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("post_rst_tx_en", bus.tx_en, 0);
      chk("post_rst_level", bus.level, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
